// File: rtl/key_poll_master.sv
// key_poll_master: Avalon-MM poller for a key PIO with per-key debounce, press/release pulses and bus anomaly flags
module key_poll_master #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int KEY_W = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int POLL_CYCLES = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_status,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic [KEY_W-1:0]  key_state,
  output logic [KEY_W-1:0]  key_press,
  output logic [KEY_W-1:0]  key_release,
  output logic              read_timeout,
  output logic              poll_overrun
);
  localparam int PT_W = $clog2(POLL_CYCLES);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PT_W-1:0] PT_MAX = PT_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SAMPLES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;
  state_t state_q, state_d;
  logic [PT_W-1:0] timer_q, timer_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic [KEY_W-1:0] sample_q, sample_d, key_q, key_d, press_q, press_d, rel_q, rel_d;
  logic [3:0] cnt_q [KEY_W];
  logic [3:0] cnt_d [KEY_W];
  logic rto_q, rto_d, ovr_q, ovr_d;
  logic tick, timeout;
  // State register: every flop, cleared asynchronously so a reset mid-read drops avm_read at once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= PT_MAX;
      tcnt_q   <= '0;
      sample_q <= '0;
      key_q    <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      cnt_q    <= '{default: 4'd0};
      rto_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
      sample_q <= sample_d;
      key_q    <= key_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      cnt_q    <= cnt_d;
      rto_q    <= rto_d;
      ovr_q    <= ovr_d;
    end
  // Next state: poll tick, read handshake and response watchdog
  always_comb begin
    tick = enable && timer_q == '0;
    timer_d = (!enable || tick) ? PT_MAX : timer_q - 1'b1;
    timeout = state_q == WAIT && !avm_readdatavalid && tcnt_q == TO_LAST;
    tcnt_d = state_q == WAIT ? tcnt_q + 1'b1 : '0;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tick ? REQ : IDLE;
      REQ:     state_d = avm_waitrequest ? REQ : WAIT;
      WAIT:    state_d = avm_readdatavalid ? UPDATE : (timeout ? IDLE : WAIT);
      default: state_d = IDLE;
    endcase
  end
  // Outputs: sample capture, per-key debounce with edge pulses, sticky flags where a set beats a clear
  always_comb begin
    sample_d = (state_q == WAIT && avm_readdatavalid) ?
               (ACTIVE_LOW ? ~avm_readdata[KEY_W-1:0] : avm_readdata[KEY_W-1:0]) : sample_q;
    key_d = key_q;
    press_d = '0;
    rel_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < KEY_W; i++)
      if (state_q == UPDATE) begin
        cnt_d[i] = sample_q[i] == key_q[i] ? 4'd0 : cnt_q[i] + 4'd1;
        if (cnt_d[i] == DB_N) begin
          key_d[i] = ~key_q[i];
          cnt_d[i] = 4'd0;
          press_d[i] = ~key_q[i];
          rel_d[i] = key_q[i];
        end
      end
    rto_d = timeout | (rto_q & ~clear_status);
    ovr_d = (tick && state_q != IDLE) | (ovr_q & ~clear_status);
  end
  assign avm_address  = BASE_ADDR;
  assign avm_read     = state_q == REQ;
  assign key_state    = key_q;
  assign key_press    = press_q;
  assign key_release  = rel_q;
  assign read_timeout = rto_q;
  assign poll_overrun = ovr_q;
endmodule

// File: tb/tb_key_poll_master.sv
// tb_key_poll_master: drives the key poller as a PIO responder and checks it against a per-key streak model
module tb_key_poll_master;
  localparam int POLL = 16;
  localparam int DB = 3;
  localparam int TO = 10;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear_status = 1'b0;
  logic avm_waitrequest = 1'b0;
  logic avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic [31:0] avm_address;
  logic avm_read;
  logic [3:0] key_state, key_press, key_release;
  logic read_timeout, poll_overrun;

  int checks = 0;
  int errors = 0;

  // Reference: debounced state plus the run length of samples disagreeing with it, per key
  logic [3:0] m_state, m_press, m_rel;
  int m_streak [4];

  key_poll_master #(
    .ADDR_W(32), .BASE_ADDR(BASE), .KEY_W(4), .ACTIVE_LOW(1'b1),
    .POLL_CYCLES(POLL), .DEBOUNCE_SAMPLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_status(clear_status),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .read_timeout(read_timeout), .poll_overrun(poll_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset;
    m_state = 4'h0;
    m_press = 4'h0;
    m_rel = 4'h0;
    for (int i = 0; i < 4; i++) m_streak[i] = 0;
  endtask

  task automatic model_apply(input logic [31:0] d);
    logic [3:0] p;
    p = ~d[3:0];
    m_press = 4'h0;
    m_rel = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] == m_state[i]) m_streak[i] = 0;
      else begin
        m_streak[i] = m_streak[i] + 1;
        if (m_streak[i] == DB) begin
          m_streak[i] = 0;
          m_state[i] = p[i];
          if (p[i]) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
        end
      end
    end
  endtask

  // One poll as seen from the responder: optional wait states, then a response or a missing one
  task automatic do_poll(input logic [31:0] d, input int ws, input bit drop, input bit en_off);
    int n;
    n = 0;
    while (avm_read !== 1'b1 && n < 4 * POLL) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (avm_read !== 1'b1) begin
      errors++;
      $display("FAIL poll_start avm_read=%b want 1", avm_read);
      return;
    end
    if (en_off) enable = 1'b0;
    for (int k = 0; k < ws; k++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      checks++;
      if (avm_read !== 1'b1 || avm_address !== BASE) begin
        errors++;
        $display("FAIL req_hold read=%b addr=%h want 1 %h", avm_read, avm_address, BASE);
      end
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (avm_read !== 1'b0) begin
      errors++;
      $display("FAIL single_read avm_read=%b want 0", avm_read);
    end
    if (drop) begin
      repeat (TO - 1) @(negedge clk);
      checks++;
      if (read_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early read_timeout=%b want 0", read_timeout);
      end
      @(negedge clk);
      checks++;
      if (read_timeout !== 1'b1) begin
        errors++;
        $display("FAIL timeout_set read_timeout=%b want 1", read_timeout);
      end
      checks++;
      if (key_state !== m_state) begin
        errors++;
        $display("FAIL timeout_keys key_state=%h want %h", key_state, m_state);
      end
    end else begin
      avm_readdatavalid = 1'b1;
      avm_readdata = d;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      checks++;
      if (key_state !== m_state) begin
        errors++;
        $display("FAIL state_early key_state=%h want %h", key_state, m_state);
      end
      model_apply(d);
      @(negedge clk);
      checks++;
      if ({key_state, key_press, key_release} !== {m_state, m_press, m_rel}) begin
        errors++;
        $display("FAIL update state/press/release=%h/%h/%h want %h/%h/%h",
                 key_state, key_press, key_release, m_state, m_press, m_rel);
      end
      @(negedge clk);
      checks++;
      if ({key_press, key_release} !== 8'h00) begin
        errors++;
        $display("FAIL pulse_width press/release=%h/%h want 0/0", key_press, key_release);
      end
    end
    if (en_off) enable = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({avm_read, key_state, key_press, key_release, read_timeout, poll_overrun} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs read=%b state=%h press=%h rel=%h to=%b ov=%b want all 0",
               avm_read, key_state, key_press, key_release, read_timeout, poll_overrun);
    end
    checks++;
    if (avm_address !== BASE) begin
      errors++;
      $display("FAIL address avm_address=%h want %h", avm_address, BASE);
    end
    model_reset();
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_press;
    do_poll(32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) do_poll(32'hFFFF_FFFE, 0, 1'b0, 1'b0);
    checks++;
    if (key_state !== 4'b0001) begin
      errors++;
      $display("FAIL press_state key_state=%b want 0001", key_state);
    end
  endtask

  task automatic test_release;
    for (int k = 0; k < 3; k++) do_poll(32'h0000_000F, 0, 1'b0, 1'b0);
    checks++;
    if (key_state !== 4'b0000) begin
      errors++;
      $display("FAIL release_state key_state=%b want 0000", key_state);
    end
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 6; k++) do_poll(k[0] ? 32'h0000_000F : 32'h0000_000E, 0, 1'b0, 1'b0);
    checks++;
    if (key_state !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_hold key_state=%b want 0000", key_state);
    end
    for (int k = 0; k < 3; k++) do_poll(32'h0000_000E, 0, 1'b0, 1'b0);
    checks++;
    if (key_state !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_settle key_state=%b want 0001", key_state);
    end
  endtask

  task automatic test_waitrequest;
    do_poll(32'hABCD_000E, 5, 1'b0, 1'b0);
    do_poll(32'h0000_000C, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    do_poll(32'h0, 0, 1'b1, 1'b0);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    checks++;
    if (read_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear read_timeout=%b want 0", read_timeout);
    end
    do_poll(32'h0000_000C, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun;
    checks++;
    if (poll_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_idle poll_overrun=%b want 0", poll_overrun);
    end
    do_poll(32'h0000_000C, POLL + 4, 1'b0, 1'b0);
    checks++;
    if (poll_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set poll_overrun=%b want 1", poll_overrun);
    end
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    checks++;
    if (poll_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear poll_overrun=%b want 0", poll_overrun);
    end
  endtask

  task automatic test_enable;
    bit seen;
    seen = 1'b0;
    enable = 1'b0;
    repeat (3 * POLL) begin
      @(negedge clk);
      if (avm_read === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL disabled_read avm_read seen=1 want 0");
    end
    enable = 1'b1;
    do_poll(32'h0000_0003, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [31:0] d, last;
    last = 32'h0000_000F;
    for (int k = 0; k < 30; k++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[3:0] = last[3:0];
      last = d;
      do_poll(d, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
    checks++;
    if (poll_overrun !== 1'b0 || read_timeout !== 1'b0) begin
      errors++;
      $display("FAIL random_flags ov/to=%b/%b want 0/0", poll_overrun, read_timeout);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (avm_read !== 1'b1 && n < 4 * POLL) begin
      @(negedge clk);
      n++;
    end
    avm_waitrequest = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, key_state, key_press, key_release, read_timeout, poll_overrun} !== 15'h0) begin
      errors++;
      $display("FAIL reset_async read=%b state=%h press=%h rel=%h to=%b ov=%b want all 0",
               avm_read, key_state, key_press, key_release, read_timeout, poll_overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({avm_read, key_state, key_press, key_release} !== 13'h0) begin
      errors++;
      $display("FAIL late_valid read=%b state=%h press=%h rel=%h want all 0",
               avm_read, key_state, key_press, key_release);
    end
    model_reset();
    do_poll(32'h0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_waitrequest();
    test_timeout();
    test_overrun();
    test_enable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
